mem_arbiter: RTL

Two-master, one-slave arbiter on the native memory bus (valid/ready, addr/wdata/wstrb/rdata, instr). It lets the CPU core (port m0) and a second requester such as a DMA or debug loader (port m1) share the single on-chip memory. Grants are round-robin, and only one transfer is outstanding at a time. A per-grant timeout completes a hung transfer with an error word and a sticky error flag, so a master never stalls forever.

---
 rtl/mem_arbiter_if.sv | 14 +
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Native memory bus: request (valid/instr/addr/wdata/wstrb) and single-cycle completion (ready/rdata).
// The master modport issues requests; the slave modport answers them.
interface mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-master memory arbiter: one transfer outstanding, grant 1 cycle after request, zero-latency response path.
// Losers hold their request; a per-grant timeout completes hung transfers with ERR_RDATA and a sticky error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_arbiter_if.slave         m0,
    mem_arbiter_if.slave         m1,
    mem_arbiter_if.master        s,
    output logic [1:0]           grant,
    output logic                 timeout_err,
    output logic [31:0]          err_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;   // 1: m1 owned the most recent grant
    logic [15:0] cnt;
    logic        timeout_fire;
    logic        rsp;
    logic [31:0] rsp_rdata;

    logic        sel_valid;
    logic        sel_instr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    always_comb begin
        sel_valid = 1'b0;
        sel_instr = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        case (state)
            GRANT0: begin
                sel_valid = m0.valid;
                sel_instr = m0.instr;
                sel_addr  = m0.addr;
                sel_wdata = m0.wdata;
                sel_wstrb = m0.wstrb;
            end
            GRANT1: begin
                sel_valid = m1.valid;
                sel_instr = m1.instr;
                sel_addr  = m1.addr;
                sel_wdata = m1.wdata;
                sel_wstrb = m1.wstrb;
            end
            default: ;
        endcase
    end

    assign timeout_fire = (TO_LIMIT != 16'd0) && (state != IDLE) &&
                          (cnt == TO_LIMIT) && !s.ready;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0.valid && (!m1.valid || last_grant)) state_nxt = GRANT0;
                else if (m1.valid)                         state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (s.ready || timeout_fire || !sel_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        grant     = state;
        s.valid   = 1'b0;
        s.instr   = 1'b0;
        s.addr    = '0;
        s.wdata   = '0;
        s.wstrb   = '0;
        m0.ready  = 1'b0;
        m0.rdata  = '0;
        m1.ready  = 1'b0;
        m1.rdata  = '0;
        rsp       = s.ready | timeout_fire;
        // A real slave response always beats the timeout in the same cycle
        rsp_rdata = s.ready ? s.rdata : ERR_RDATA;
        if (state != IDLE) begin
            s.valid = sel_valid & ~timeout_fire;
            s.instr = sel_instr;
            s.addr  = sel_addr;
            s.wdata = sel_wdata;
            s.wstrb = sel_wstrb;
        end
        if (state == GRANT0) begin
            m0.ready = rsp;
            m0.rdata = rsp ? rsp_rdata : '0;
        end
        if (state == GRANT1) begin
            m1.ready = rsp;
            m1.rdata = rsp ? rsp_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (state == IDLE) begin
            if (state_nxt == GRANT0)      last_grant <= 1'b0;
            else if (state_nxt == GRANT1) last_grant <= 1'b1;
        end
    end

    // Every grant is entered from IDLE, so holding cnt at zero there clears it per grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (!s.ready && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
            err_addr    <= '0;
        end else if (timeout_fire) begin
            timeout_err <= 1'b1;
            err_addr    <= sel_addr;
        end
    end

endmodule
